// File: rtl/cp0_int_ctrl.sv
// cp0_int_ctrl: interrupt front-end that drives CP0's 8-bit int_i input.
// Each of the six asynchronous hardware lines goes through a synchroniser
// and a glitch filter. The block also owns the Compare register and raises
// the timer interrupt, which is ORed onto hardware line 5 (Cause.IP7).
module cp0_int_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3,
  parameter logic [4:0]  CP0_COMPARE = 5'd11
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic [5:0]  ext_int_i,
  input  logic [31:0] cnt_i,
  input  logic        wb_cp0_we,
  input  logic [4:0]  wb_cp0_waddr_0,
  input  logic [4:0]  wb_cp0_waddr_1,
  input  logic [31:0] wb_cp0_wdata_0,
  input  logic [31:0] wb_cp0_wdata_1,
  input  logic        exc_flush_all,
  output logic [7:0]  int_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  // Filter counter width: wide enough to hold FILTER_LEN-1 with headroom.
  localparam int unsigned      FCW     = $clog2(FILTER_LEN) + 1;
  localparam logic [FCW-1:0]   FC_ZERO = FCW'(0);
  localparam logic [FCW-1:0]   FC_ONE  = FCW'(1);
  localparam logic [FCW-1:0]   FC_LAST = FCW'(FILTER_LEN - 1);

  // Synchroniser chain: index 0 is the first flop, SYNC_STAGES-1 the last.
  logic [SYNC_STAGES-1:0][5:0] sync_q;
  logic [5:0]                  sync_s;

  // Filtered levels and per-line run counters.
  logic [5:0]          filt_q;
  logic [5:0]          filt_d;
  logic [5:0][FCW-1:0] fc_q;
  logic [5:0][FCW-1:0] fc_d;

  // Compare register and timer state.
  logic [31:0] compare_q;
  logic [31:0] compare_d;
  logic        ti_pending_q;
  logic        ti_pending_d;
  logic        ti_armed_q;
  logic        ti_armed_d;

  // MTC0 decode.
  logic        wr0_s;
  logic        wr1_s;
  logic        cmp_wr_s;
  logic [31:0] cmp_wdata_s;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Shift every interrupt line through its synchroniser chain.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      sync_q <= {SYNC_STAGES{6'd0}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ext_int_i};
    end
  end

  // Filter next-state: a new level must persist FILTER_LEN cycles to be taken.
  always_comb begin
    filt_d = filt_q;
    fc_d   = fc_q;
    for (int i = 0; i < 6; i++) begin
      if (sync_s[i] == filt_q[i]) begin
        fc_d[i] = FC_ZERO;
      end else if (fc_q[i] == FC_LAST) begin
        filt_d[i] = sync_s[i];
        fc_d[i]   = FC_ZERO;
      end else begin
        fc_d[i] = fc_q[i] + FC_ONE;
      end
    end
  end

  // Filter state registers.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      filt_q <= 6'd0;
      fc_q   <= {6{FC_ZERO}};
    end else begin
      filt_q <= filt_d;
      fc_q   <= fc_d;
    end
  end

  // Compare write decode; a flushed WB write never lands, way 1 has priority.
  always_comb begin
    wr0_s       = wb_cp0_we & ~exc_flush_all & (wb_cp0_waddr_0 == CP0_COMPARE);
    wr1_s       = wb_cp0_we & ~exc_flush_all & (wb_cp0_waddr_1 == CP0_COMPARE);
    cmp_wr_s    = wr0_s | wr1_s;
    if (wr1_s) begin
      cmp_wdata_s = wb_cp0_wdata_1;
    end else begin
      cmp_wdata_s = wb_cp0_wdata_0;
    end
  end

  // Timer next-state: a write re-arms and clears; a match on an armed
  // Compare sets pending, which then sticks until the next write.
  always_comb begin
    compare_d    = compare_q;
    ti_pending_d = ti_pending_q;
    ti_armed_d   = ti_armed_q;
    if (cmp_wr_s) begin
      compare_d    = cmp_wdata_s;
      ti_pending_d = 1'b0;
      ti_armed_d   = 1'b1;
    end else if (ti_armed_q && (cnt_i == compare_q)) begin
      ti_pending_d = 1'b1;
    end else begin
      ti_pending_d = ti_pending_q;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      compare_q    <= 32'd0;
      ti_pending_q <= 1'b0;
      ti_armed_q   <= 1'b0;
    end else begin
      compare_q    <= compare_d;
      ti_pending_q <= ti_pending_d;
      ti_armed_q   <= ti_armed_d;
    end
  end

  // Outputs are flop-driven; bit 5 merges the timer onto hardware line 5.
  assign int_o       = {2'b00, filt_q[5] | ti_pending_q, filt_q[4:0]};
  assign compare_o   = compare_q;
  assign timer_int_o = ti_pending_q;

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Scoreboard bench for cp0_int_ctrl: a stimulus process drives one cycle of
// inputs per falling edge and pushes the predicted post-edge outputs; a
// monitor pops and compares one entry after every rising edge.
module tb_cp0_int_ctrl;

  localparam int S = 2;
  localparam int F = 3;
  localparam logic [4:0] CMP_ADDR = 5'd11;

  logic        clk = 1'b1;
  logic        rst_ = 1'b0;
  logic [5:0]  ext_int_i = 6'd0;
  logic [31:0] cnt_i = 32'd0;
  logic        wb_cp0_we = 1'b0;
  logic [4:0]  wb_cp0_waddr_0 = 5'd0;
  logic [4:0]  wb_cp0_waddr_1 = 5'd0;
  logic [31:0] wb_cp0_wdata_0 = 32'd0;
  logic [31:0] wb_cp0_wdata_1 = 32'd0;
  logic        exc_flush_all = 1'b0;
  logic [7:0]  int_o;
  logic [31:0] compare_o;
  logic        timer_int_o;

  cp0_int_ctrl #(.SYNC_STAGES(S), .FILTER_LEN(F), .CP0_COMPARE(CMP_ADDR)) dut (
    .clk            (clk),
    .rst_           (rst_),
    .ext_int_i      (ext_int_i),
    .cnt_i          (cnt_i),
    .wb_cp0_we      (wb_cp0_we),
    .wb_cp0_waddr_0 (wb_cp0_waddr_0),
    .wb_cp0_waddr_1 (wb_cp0_waddr_1),
    .wb_cp0_wdata_0 (wb_cp0_wdata_0),
    .wb_cp0_wdata_1 (wb_cp0_wdata_1),
    .exc_flush_all  (exc_flush_all),
    .int_o          (int_o),
    .compare_o      (compare_o),
    .timer_int_o    (timer_int_o)
  );

  // Free-running clock; first falling edge at 5, first rising edge at 10.
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  io;
    logic [31:0] cmp;
    logic        ti;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model: raw input history plus the architectural timer state.
  logic [5:0]  mh [S+F];
  logic [5:0]  m_filt = 6'd0;
  logic [31:0] m_cmp = 32'd0;
  logic        m_armed = 1'b0;
  logic        m_pend = 1'b0;

  // Advance the model by one rising edge with the given inputs.
  task automatic model_edge(input logic r, input logic [5:0] e, input logic [31:0] c,
                            input logic we, input logic [4:0] a0, input logic [4:0] a1,
                            input logic [31:0] d0, input logic [31:0] d1, input logic fl);
    logic w0;
    logic w1;
    logic all_diff;
    if (!r) begin
      for (int d = 0; d < S + F; d++) mh[d] = 6'd0;
      m_filt  = 6'd0;
      m_cmp   = 32'd0;
      m_armed = 1'b0;
      m_pend  = 1'b0;
    end else begin
      // The filter at this edge sees the input sampled S edges earlier;
      // it follows a line once F consecutive such samples disagree with it.
      for (int d = S + F - 1; d > 0; d--) mh[d] = mh[d-1];
      mh[0] = e;
      for (int i = 0; i < 6; i++) begin
        all_diff = 1'b1;
        for (int d = S; d < S + F; d++) begin
          if (mh[d][i] == m_filt[i]) all_diff = 1'b0;
        end
        if (all_diff) m_filt[i] = ~m_filt[i];
      end
      w0 = we && !fl && (a0 == CMP_ADDR);
      w1 = we && !fl && (a1 == CMP_ADDR);
      if (w0 || w1) begin
        m_cmp   = w1 ? d1 : d0;
        m_pend  = 1'b0;
        m_armed = 1'b1;
      end else if (m_armed && (c == m_cmp)) begin
        m_pend = 1'b1;
      end
    end
  endtask

  // Drive one cycle of inputs and queue the expected outputs after the edge.
  task automatic step(input logic r, input logic [5:0] e, input logic [31:0] c,
                      input logic we, input logic [4:0] a0, input logic [4:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1, input logic fl);
    exp_t x;
    @(negedge clk);
    rst_           = r;
    ext_int_i      = e;
    cnt_i          = c;
    wb_cp0_we      = we;
    wb_cp0_waddr_0 = a0;
    wb_cp0_waddr_1 = a1;
    wb_cp0_wdata_0 = d0;
    wb_cp0_wdata_1 = d1;
    exc_flush_all  = fl;
    if (!r) begin
      #1;
      total += 1;
      if (int_o !== 8'd0 || compare_o !== 32'd0 || timer_int_o !== 1'b0) begin
        bad += 1;
        $display("FAIL async_reset t=%0t got int=%h cmp=%h ti=%b required all zero",
                 $time, int_o, compare_o, timer_int_o);
      end
    end
    model_edge(r, e, c, we, a0, a1, d0, d1, fl);
    x.io  = {2'b00, m_filt[5] | m_pend, m_filt[4:0]};
    x.cmp = m_cmp;
    x.ti  = m_pend;
    exp_q.push_back(x);
  endtask

  task automatic idle(input logic [5:0] e, input logic [31:0] c);
    step(1'b1, e, c, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic wr(input logic [5:0] e, input logic [31:0] c, input logic [4:0] a0,
                    input logic [4:0] a1, input logic [31:0] d0, input logic [31:0] d1,
                    input logic fl);
    step(1'b1, e, c, 1'b1, a0, a1, d0, d1, fl);
  endtask

  // Monitor: one output sample per rising edge, checked against the queue.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      cyc += 1;
      if (exp_q.size() == 0) begin
        total += 1;
        bad   += 1;
        $display("FAIL scoreboard_empty cyc=%0d got no expectation required one", cyc);
      end else begin
        x = exp_q.pop_front();
        total += 3;
        if (int_o !== x.io) begin
          bad += 1;
          $display("FAIL int_o cyc=%0d got=%h exp=%h", cyc, int_o, x.io);
        end
        if (compare_o !== x.cmp) begin
          bad += 1;
          $display("FAIL compare_o cyc=%0d got=%h exp=%h", cyc, compare_o, x.cmp);
        end
        if (timer_int_o !== x.ti) begin
          bad += 1;
          $display("FAIL timer_int_o cyc=%0d got=%b exp=%b", cyc, timer_int_o, x.ti);
        end
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog expired before stimulus completed");
    $fatal(1, "watchdog");
  end

  // Stimulus: directed scenarios first, then randomized traffic.
  initial begin
    logic [5:0]  cur_e;
    logic [31:0] cur_c;
    logic        r;
    logic        we;
    logic        fl;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    for (int d = 0; d < S + F; d++) mh[d] = 6'd0;

    // Reset held with all lines high and Count at zero.
    repeat (3) step(1'b0, 6'h3F, 32'd0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0);
    // Count=0 equals the reset Compare but must not fire.
    repeat (100) idle(6'h00, 32'd0);

    // Line 2 held for 10 cycles, then dropped.
    repeat (10) idle(6'h04, 32'd1);
    repeat (10) idle(6'h00, 32'd1);

    // Line 0: 2-cycle glitch, gap, 1-cycle glitch.
    repeat (2) idle(6'h01, 32'd2);
    repeat (8) idle(6'h00, 32'd2);
    idle(6'h01, 32'd2);
    repeat (8) idle(6'h00, 32'd2);

    // Compare=0x10 and Count stepping through it; then a rewrite clears.
    wr(6'h00, 32'd0, CMP_ADDR, 5'd0, 32'h0000_0010, 32'd0, 1'b0);
    idle(6'h00, 32'h0E);
    idle(6'h00, 32'h0F);
    idle(6'h00, 32'h10);
    idle(6'h00, 32'h11);
    idle(6'h00, 32'h12);
    wr(6'h00, 32'h13, CMP_ADDR, 5'd0, 32'h0000_0100, 32'd0, 1'b0);
    idle(6'h00, 32'h14);

    // Both ways write Compare while Count matches the old value.
    wr(6'h00, 32'h0, CMP_ADDR, 5'd0, 32'd7, 32'd0, 1'b0);
    wr(6'h00, 32'd7, CMP_ADDR, CMP_ADDR, 32'd5, 32'd9, 1'b0);
    idle(6'h00, 32'd7);
    idle(6'h00, 32'd8);

    // Equal-value rewrite re-arms; a flushed write is discarded.
    idle(6'h00, 32'd9);
    wr(6'h00, 32'd0, CMP_ADDR, 5'd0, 32'd9, 32'd0, 1'b0);
    idle(6'h00, 32'd9);
    wr(6'h00, 32'd0, CMP_ADDR, CMP_ADDR, 32'h55, 32'h66, 1'b1);
    idle(6'h00, 32'd1);

    // Mid-operation reset drops the pending timer interrupt.
    step(1'b0, 6'h3F, 32'd9, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0);
    repeat (4) idle(6'h00, 32'd0);

    // Randomized traffic.
    cur_e = 6'd0;
    cur_c = 32'd0;
    for (int n = 0; n < 2000; n++) begin
      r = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 3) == 0) cur_e = cur_e ^ (6'($urandom) & 6'($urandom));
      case ($urandom_range(0, 3))
        0:       cur_c = m_cmp;
        1:       cur_c = cur_c + 32'd1;
        2:       cur_c = m_cmp + 32'($urandom_range(0, 2)) - 32'd1;
        default: cur_c = $urandom;
      endcase
      we = ($urandom_range(0, 5) == 0);
      fl = ($urandom_range(0, 7) == 0);
      a0 = ($urandom_range(0, 2) == 0) ? CMP_ADDR : 5'($urandom);
      a1 = ($urandom_range(0, 2) == 0) ? CMP_ADDR : 5'($urandom);
      d0 = ($urandom_range(0, 1) == 0) ? (cur_c + 32'($urandom_range(0, 4))) : $urandom;
      d1 = ($urandom_range(0, 1) == 0) ? (cur_c + 32'($urandom_range(0, 4))) : $urandom;
      step(r, cur_e, cur_c, we, a0, a1, d0, d1, fl);
    end

    @(posedge clk);
    #2;
    total += 1;
    if (exp_q.size() != 0) begin
      bad += 1;
      $display("FAIL scoreboard_drain got=%0d entries left required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cp0_int_ctrl.md
Name: cp0_int_ctrl

Overview:
- Interrupt front-end that sits directly upstream of CP0 and drives CP0's 8-bit `int_i` interrupt input.
- Synchronises and de-glitches the six asynchronous hardware interrupt lines.
- Owns the CP0 Compare register (reg 11) and raises the MIPS timer interrupt when the CP0 Count value reaches Compare.
- Merges the timer interrupt onto hardware line 5, which CP0 stores in Cause.IP7.

Parameters:
- SYNC_STAGES, 2, flops in each interrupt-line synchroniser; minimum 2.
- FILTER_LEN, 3, consecutive cycles a synchronised line must hold a new level before the filtered level follows it; minimum 1.
- CP0_COMPARE, 11, CP0 register address of Compare.

Ports:
- clk  in  1  system clock
- rst_  in  1  asynchronous active-low reset
- ext_int_i  in  6  asynchronous hardware interrupt lines, active-high, level-sensitive
- cnt_i  in  32  current CP0 Count value from CP0
- wb_cp0_we  in  1  MTC0 write enable from WB
- wb_cp0_waddr_0  in  5  way-0 MTC0 address
- wb_cp0_waddr_1  in  5  way-1 MTC0 address
- wb_cp0_wdata_0  in  32  way-0 MTC0 data
- wb_cp0_wdata_1  in  32  way-1 MTC0 data
- exc_flush_all  in  1  CP0 exception flush; a WB write in the same cycle is discarded
- int_o  out  8  to CP0 `int_i`: [4:0] filtered ext lines, [5] filtered ext_int_i[5] OR timer pending, [7:6] tied 0
- compare_o  out  32  Compare register contents, for CP0's MFC0 read mux
- timer_int_o  out  1  timer interrupt pending (Cause.TI)

Behaviour:
- Reset is asynchronous and active-low on `rst_`; the clock is `clk`. While `rst_`=0:
  - all synchroniser flops, filtered levels and filter counters = 0
  - compare = 0, ti_pending = 0, ti_armed = 0
  - int_o = 0, compare_o = 0, timer_int_o = 0
- Reset asserted mid-operation clears all state immediately; a pending timer interrupt is lost.
- Synchroniser: per line, a chain of SYNC_STAGES flops. `sync[i]` is the last flop.
- Filter, per line, using filt[i] and a counter fc[i] of width clog2(FILTER_LEN)+1:
  - sync == filt: fc <= 0.
  - sync != filt and fc == FILTER_LEN-1: filt <= sync, fc <= 0.
  - otherwise: fc <= fc+1.
  - A pulse held for fewer than FILTER_LEN synchronised cycles never reaches filt.
- Latency: an input held stable from before edge 1 changes int_o just after edge SYNC_STAGES+FILTER_LEN (edge 5 with defaults). Falling transitions take the same latency.
- Compare write condition: wb_cp0_we=1, exc_flush_all=0, and either waddr equals CP0_COMPARE.
  - If both ways target Compare, way 1 wins (matches CP0's own MTC0 priority).
  - On a write: compare <= data, ti_pending <= 0, ti_armed <= 1.
- Timer match:
  - If ti_armed=1, cnt_i == compare (the current register value) and there is no Compare write this cycle: ti_pending <= 1.
  - Visible on timer_int_o and int_o[5] the cycle after the match cycle.
  - Stays set until the next Compare write or reset; Count wrap-around does not clear it.
- Simultaneous Compare write and match: the write wins; ti_pending = 0 next cycle.
- ti_armed exists so that Count=0 == Compare=0 after reset does not fire. It is never cleared except by reset.
- A write with an equal Compare value re-arms and clears pending. A match can then occur again the next time Count equals that value.
- compare_o reflects a write one cycle after the write edge (registered); no bypass.
- int_o[5] = filt[5] | ti_pending, combinational OR of two flops. All other int_o bits come directly from flops.

Test Plan:
- Reset held low 3 cycles with ext_int_i=6'h3F and cnt_i=0 -> int_o=0, timer_int_o=0. After release with cnt_i=0 and no Compare write, timer_int_o stays 0 for 100 cycles.
- Set ext_int_i[2]=1 held, then dropped to 0 after 10 cycles -> int_o[2] rises just after edge 5 and falls 5 edges after the drop. Other bits stay 0.
- ext_int_i[0] glitch high for 2 cycles; separately, a 1-cycle pulse -> int_o[0] never rises (FILTER_LEN=3).
- MTC0 way0 addr 11 data 32'h0000_0010, then cnt_i stepping 0x0E, 0x0F, 0x10, 0x11 -> compare_o=0x10 after the write, timer_int_o=1 and int_o[5]=1 the cycle after cnt_i=0x10, held through cnt_i=0x11. A later MTC0 to 11 clears them next cycle.
- Same cycle: way0 writes Compare=5, way1 writes Compare=9, and cnt_i equals the old compare -> compare_o=9, timer_int_o=0.
- MTC0 to Compare with exc_flush_all=1 -> compare_o unchanged, ti_pending unchanged.
